// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: two-stage register-file/ALU datapath with valid/ready in and out.
// Ports: clk; rst (async, active-low); in_valid/in_ready + src1_addr, src2_addr, dst_addr,
//   wb_en, write_sel, write_data, alu_op (instruction); out_valid/out_ready + out_data,
//   out_overflow (result). Macro ALU_FWD_EN: forward the EX result into operand capture
//   instead of stalling one cycle on a read-after-write dependency.
module alu_regfile_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              wb_en,
  input  logic              write_sel,
  input  logic [DATA_W-1:0] write_data,
  input  logic [OP_W-1:0]   alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_overflow
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int M = DATA_W - 1;
  logic [DATA_W-1:0] rf [2**ADDR_W];
  logic              ex_valid, ex_wb_en, ex_sel;
  logic [DATA_W-1:0] ex_a, ex_b, ex_wdata;
  logic [ADDR_W-1:0] ex_dst;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] sum, diff, alu_res, res, op_a, op_b;
  logic [SH_W-1:0]   sh;
  logic              alu_ovf, ovf, adv, hazard, accept;
  assign adv      = !out_valid || out_ready;
  assign in_ready = rst && adv && !hazard;
  assign accept   = in_valid && in_ready;
  always_comb begin
    sum     = ex_a + ex_b;
    diff    = ex_a - ex_b;
    sh      = ex_b[SH_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ex_op)
      OP_W'(0): begin
        alu_res = sum;
        alu_ovf = (ex_a[M] == ex_b[M]) && (sum[M] != ex_a[M]);
      end
      OP_W'(1): begin
        alu_res = diff;
        alu_ovf = (ex_a[M] != ex_b[M]) && (diff[M] != ex_a[M]);
      end
      OP_W'(2):  alu_res = ex_a & ex_b;
      OP_W'(3):  alu_res = ex_a | ex_b;
      OP_W'(4):  alu_res = ex_a ^ ex_b;
      OP_W'(5):  alu_res = ~(ex_a | ex_b);
      OP_W'(6):  alu_res = ex_a << sh;
      OP_W'(7):  alu_res = ex_a >> sh;
      OP_W'(8):  alu_res = $signed(ex_a) >>> sh;
      OP_W'(9):  alu_res = {{(DATA_W-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_W'(10): alu_res = ex_a;
      default:   alu_res = '0;
    endcase
    res = ex_sel ? alu_res : ex_wdata;
    ovf = ex_sel && alu_ovf;
  end
`ifdef ALU_FWD_EN
  // The EX result is written on the same edge the new operands are captured, so take it directly.
  always_comb begin
    op_a   = (ex_valid && ex_wb_en && src1_addr == ex_dst) ? res : rf[src1_addr];
    op_b   = (ex_valid && ex_wb_en && src2_addr == ex_dst) ? res : rf[src2_addr];
    hazard = 1'b0;
  end
`else
  // Hold a dependent instruction until its producer has left EX and been written back.
  always_comb begin
    op_a   = rf[src1_addr];
    op_b   = rf[src2_addr];
    hazard = ex_valid && ex_wb_en && (src1_addr == ex_dst || src2_addr == ex_dst);
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_sel       <= 1'b0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_wdata     <= '0;
      ex_dst       <= '0;
      ex_op        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else if (adv) begin
      ex_valid     <= accept;
      ex_wb_en     <= wb_en;
      ex_sel       <= write_sel;
      ex_a         <= op_a;
      ex_b         <= op_b;
      ex_wdata     <= write_data;
      ex_dst       <= dst_addr;
      ex_op        <= alu_op;
      out_valid    <= ex_valid;
      out_data     <= ex_valid ? res : out_data;
      out_overflow <= ex_valid ? ovf : out_overflow;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) rf[i] <= '0;
    end else if (adv && ex_valid && ex_wb_en) begin
      rf[ex_dst] <= res;
    end
  end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: directed self-checking bench for alu_regfile_pipe.
module tb_alu_regfile_pipe;
  localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, NOR_ = 5;
  localparam logic [3:0] SLL = 6, SRL = 7, SRA = 8, SLT = 9, PASS = 10, BAD = 15;
`ifdef ALU_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif
  logic        clk = 0, rst = 0;
  logic        in_valid = 0, in_ready, wb_en = 0, write_sel = 0, out_valid, out_ready = 1, out_overflow;
  logic [5:0]  src1_addr = 0, src2_addr = 0, dst_addr = 0;
  logic [31:0] write_data = 0, out_data;
  logic [3:0]  alu_op = 0;
  typedef struct { logic [31:0] d; logic o; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, st = 0, dep_st = 0, wait_n = 0, drain_n = 0;

  alu_regfile_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
    .wb_en(wb_en), .write_sel(write_sel), .write_data(write_data), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] d, input logic wb, input logic sel,
                      input logic [31:0] wd, input logic [31:0] ed, input logic eo,
                      output int stalls);
    int n;
    exp_t e;
    n = 0;
    alu_op = op; src1_addr = a; src2_addr = b; dst_addr = d;
    wb_en = wb; write_sel = sel; write_data = wd; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    stalls = n;
    if (!in_ready) begin
      check("send_timeout", 64'(n), 64'd0);
      in_valid = 0;
    end else begin
      e.d = ed;
      e.o = eo;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 0;
    end
  endtask

  task automatic ld(input logic [5:0] d, input logic [31:0] v);
    int s;
    send(ADD, 6'd0, 6'd0, d, 1'b1, 1'b0, v, v, 1'b0, s);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] v);
    int s;
    send(PASS, a, 6'd0, 6'd0, 1'b0, 1'b1, 32'd0, v, 1'b0, s);
  endtask

  task automatic alu(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                     input logic [5:0] d, input logic [31:0] ed, input logic eo);
    int s;
    send(op, a, b, d, 1'b1, 1'b1, 32'd0, ed, eo, s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_out", 64'(exp_q.size()), 64'd1);
      else begin
        mon_e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.d));
        check("out_ovf", 64'(out_overflow), 64'(mon_e.o));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovf", 64'(out_overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);
    idle(1);
    // reset with two instructions in flight
    ld(6'd1, 32'd7);
    idle(3);
    out_ready = 0;
    ld(6'd5, 32'h55);
    ld(6'd6, 32'h66);
    check("inflight_valid", 64'(out_valid), 64'd1);
    rst = 0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    idle(1);
    rst = 1;
    out_ready = 1;
    rd(6'd1, 32'd0);
    rd(6'd5, 32'd0);
    rd(6'd6, 32'd0);
    // basic add/sub
    ld(6'd1, 32'd7);
    ld(6'd2, 32'd5);
    alu(ADD, 6'd1, 6'd2, 6'd3, 32'd12, 1'b0);
    alu(SUB, 6'd2, 6'd1, 6'd4, 32'hFFFF_FFFE, 1'b0);
    rd(6'd4, 32'hFFFF_FFFE);
    // signed overflow still written back
    ld(6'd1, 32'h7FFF_FFFF);
    ld(6'd2, 32'd1);
    alu(ADD, 6'd1, 6'd2, 6'd3, 32'h8000_0000, 1'b1);
    rd(6'd3, 32'h8000_0000);
    // dependent chain
    ld(6'd1, 32'd7);
    ld(6'd2, 32'd5);
    alu(ADD, 6'd1, 6'd2, 6'd3, 32'd12, 1'b0);
    send(ADD, 6'd3, 6'd3, 6'd4, 1'b1, 1'b1, 32'd0, 32'd24, 1'b0, dep_st);
    check("dep_stall", 64'(dep_st), 64'(EXP_STALL));
    rd(6'd4, 32'd24);
    // remaining ALU ops (r1=7, r2=5)
    alu(AND_, 6'd1, 6'd2, 6'd9, 32'd5, 1'b0);
    alu(OR_, 6'd1, 6'd2, 6'd9, 32'd7, 1'b0);
    alu(XOR_, 6'd1, 6'd2, 6'd9, 32'd2, 1'b0);
    alu(NOR_, 6'd1, 6'd2, 6'd9, 32'hFFFF_FFF8, 1'b0);
    alu(SLL, 6'd1, 6'd2, 6'd9, 32'hE0, 1'b0);
    ld(6'd7, 32'h8000_0000);
    ld(6'd8, 32'd4);
    alu(SRA, 6'd7, 6'd8, 6'd9, 32'hF800_0000, 1'b0);
    alu(SRL, 6'd7, 6'd8, 6'd9, 32'h0800_0000, 1'b0);
    ld(6'd8, 32'd1);
    alu(SUB, 6'd7, 6'd8, 6'd9, 32'h7FFF_FFFF, 1'b1);
    send(ADD, 6'd7, 6'd7, 6'd9, 1'b1, 1'b0, 32'h3, 32'h3, 1'b0, st);
    rd(6'd9, 32'h3);
    ld(6'd7, 32'hFFFF_FFFF);
    alu(SLT, 6'd7, 6'd8, 6'd9, 32'd1, 1'b0);
    alu(SLT, 6'd8, 6'd7, 6'd9, 32'd0, 1'b0);
    alu(BAD, 6'd7, 6'd8, 6'd9, 32'd0, 1'b0);
    // back-pressure with a stream behind it
    idle(4);
    fork
      begin
        ld(6'd10, 32'h11);
        ld(6'd11, 32'h22);
        ld(6'd12, 32'h33);
        ld(6'd13, 32'h44);
      end
      begin
        out_ready = 0;
        @(negedge clk);
        while (!out_valid && wait_n < 20) begin
          wait_n++;
          @(negedge clk);
        end
        check("bp_hold_data", 64'(out_data), 64'h11);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (2) begin
          @(negedge clk);
          check("bp_hold_data", 64'(out_data), 64'h11);
          check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    rd(6'd10, 32'h11);
    rd(6'd13, 32'h44);
    while (exp_q.size() != 0 && drain_n < 50) begin
      drain_n++;
      @(posedge clk);
    end
    check("lost_results", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
